// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, FSM states,
// default geometry and the alignment helper used at arbitration time.
package dmem_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 1024;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    // True when the access cannot be issued as encoded: reserved size code,
    // odd half address or a word address that is not 4-byte aligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the arbiter: request fields driven by the requester,
// completion pulse, load data and error flag returned by the arbiter.
interface dmem_arbiter_if import dmem_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             req;
    logic             we;
    logic [1:0]       size;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             done;
    logic [WIDTH-1:0] rdata;
    logic             err;

    modport master (
        output req, we, size, addr, wdata,
        input  done, rdata, err
    );

    modport slave (
        input  req, we, size, addr, wdata,
        output done, rdata, err
    );
endinterface

// File: rtl/dmem_lane.sv
// Little-endian lane logic: extracts a zero-extended byte/half/word from a
// memory word and merges store data into the addressed lane(s) of a word.
module dmem_lane import dmem_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       size,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] extracted,
    output logic [WIDTH-1:0] merged
);
    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] shifted;

    // Bring the addressed lane down to bit 0 before masking.
    assign shifted = word >> {addr_lo, 3'b000};

    // Zero-extend the addressed byte or half; a word passes straight through.
    always_comb begin
        extracted = '0;
        case (size)
            SZ_BYTE: extracted[7:0]  = shifted[7:0];
            SZ_HALF: extracted[15:0] = shifted[15:0];
            default: extracted       = word;
        endcase
    end

    // Per byte lane: take store data where the access covers the lane,
    // otherwise keep the old memory byte.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            localparam logic [1:0] LANE = 2'(gi % 4);
            logic       hit;
            logic [7:0] src;

            if (gi < 4) begin : g_low
                // Byte stores replicate wdata[7:0]; halves take the low or high
                // byte of wdata[15:0] depending on lane parity.
                always_comb begin
                    hit = 1'b0;
                    src = wdata[8*gi +: 8];
                    case (size)
                        SZ_BYTE: begin
                            hit = (addr_lo == LANE);
                            src = wdata[7:0];
                        end
                        SZ_HALF: begin
                            hit = (addr_lo[1] == LANE[1]);
                            src = wdata[8*(gi%2) +: 8];
                        end
                        SZ_WORD: hit = 1'b1;
                        default: hit = 1'b0;
                    endcase
                end
            end else begin : g_high
                assign hit = (size == SZ_WORD);
                assign src = wdata[8*gi +: 8];
            end

            assign merged[8*gi +: 8] = hit ? src : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/dmemory.sv
// Single-port word memory with registered read; data appears the cycle
// after the read strobe.
module dmemory import dmem_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             mem_write,
    input  logic             mem_read,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] mem_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_array [DEPTH];
    logic [AW-1:0]    index;
    logic             unused_addr_bits;

    assign index            = address[AW-1:0];
    assign unused_addr_bits = ^address[WIDTH-1:AW];

    // Write port and registered read port, block-RAM style.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem_array[index] <= write_data;
        end
        if (mem_read) begin
            mem_data <= mem_array[index];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a word memory. Sub-word stores
// are done as read-modify-write; illegal accesses complete with err and
// never touch memory.
module dmem_arbiter import dmem_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    p0,
    dmem_arbiter_if.slave    p1,
    output logic             mem_write,
    output logic             mem_read,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] write_data,
    input  logic [WIDTH-1:0] mem_data
);
    state_t           state_reg, state_next;

    logic             grant_reg;
    logic             rr_last_reg;
    logic             we_reg;
    logic [1:0]       size_reg;
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [WIDTH-1:0] merged_reg;
    logic [WIDTH-1:0] rdata_reg [2];
    logic             err_reg   [2];

    logic             any_req;
    logic             win;
    logic             sel_we;
    logic [1:0]       sel_size;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             sel_err;
    logic [WIDTH-1:0] word_idx;
    logic [WIDTH-1:0] lane_extracted;
    logic [WIDTH-1:0] lane_merged;

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        any_req   = p0.req | p1.req;
        win       = p0.req ? (p1.req ? ~rr_last_reg : 1'b0) : 1'b1;
        sel_we    = win ? p1.we    : p0.we;
        sel_size  = win ? p1.size  : p0.size;
        sel_addr  = win ? p1.addr  : p0.addr;
        sel_wdata = win ? p1.wdata : p0.wdata;
        sel_err   = misaligned(sel_size, sel_addr[1:0])
                  | ((sel_addr >> 2) >= WIDTH'(DEPTH));
    end

    assign word_idx = addr_reg >> 2;

    dmem_lane #(.WIDTH(WIDTH)) u_lane (
        .size      (size_reg),
        .addr_lo   (addr_reg[1:0]),
        .word      (mem_data),
        .wdata     (wdata_reg),
        .extracted (lane_extracted),
        .merged    (lane_merged)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and memory strobes; strobes exist only in RD and WR.
    always_comb begin
        state_next = state_reg;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = '0;
        write_data = '0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    if (sel_err) begin
                        state_next = DONE;
                    end else if (sel_we && (sel_size == SZ_WORD)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                mem_read   = 1'b1;
                address    = word_idx;
                state_next = WT;
            end
            WT: begin
                state_next = we_reg ? WR : DONE;
            end
            WR: begin
                mem_write  = 1'b1;
                address    = word_idx;
                write_data = (size_reg == SZ_WORD) ? wdata_reg : merged_reg;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant latching, lane results and per-port result registers. Results
    // are written on the edge entering DONE so they line up with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_reg    <= 1'b0;
            rr_last_reg  <= 1'b1;
            we_reg       <= 1'b0;
            size_reg     <= SZ_BYTE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            merged_reg   <= '0;
            rdata_reg[0] <= '0;
            rdata_reg[1] <= '0;
            err_reg[0]   <= 1'b0;
            err_reg[1]   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg   <= win;
                        rr_last_reg <= win;
                        we_reg      <= sel_we;
                        size_reg    <= sel_size;
                        addr_reg    <= sel_addr;
                        wdata_reg   <= sel_wdata;
                        if (sel_err) begin
                            rdata_reg[win] <= '0;
                            err_reg[win]   <= 1'b1;
                        end
                    end
                end
                WT: begin
                    if (we_reg) begin
                        merged_reg <= lane_merged;
                    end else begin
                        rdata_reg[grant_reg] <= lane_extracted;
                        err_reg[grant_reg]   <= 1'b0;
                    end
                end
                WR: begin
                    rdata_reg[grant_reg] <= '0;
                    err_reg[grant_reg]   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign p0.done  = (state_reg == DONE) && !grant_reg;
    assign p1.done  = (state_reg == DONE) &&  grant_reg;
    assign p0.rdata = rdata_reg[0];
    assign p1.rdata = rdata_reg[1];
    assign p0.err   = err_reg[0];
    assign p1.err   = err_reg[1];

endmodule
